// File: rtl/vcmux_arb.sv
// ---------------------------------------------------------------------------
// vcmux_arb
// Transmit-side virtual-channel multiplexer. VCN per-VC flit channels are
// merged onto one shared link through a single registered flit stage. The
// winning VC is picked by a round-robin arbiter and each output flit carries
// a one-hot VC tag (dovc) that serves as the select for the downstream demux.
//
// Optional feature (compile-time macro): VCMUX_PKTLOCK_EN
//   undefined : flit-level interleave, no lock register (default build)
//   defined   : packet-level lock; once a head flit (not also a tail) is
//               granted, only that VC may win until its tail transfers.
// ---------------------------------------------------------------------------
module vcmux_arb #(
  parameter int VCN = 2,
  parameter int DW  = 32,
  parameter int SCN = DW / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [VCN-1:0][SCN-1:0]  di0,
  input  logic [VCN-1:0][SCN-1:0]  di1,
  input  logic [VCN-1:0][SCN-1:0]  di2,
  input  logic [VCN-1:0][SCN-1:0]  di3,
  input  logic [VCN-1:0][2:0]      dit,
  input  logic [VCN-1:0]           div,
  output logic [VCN-1:0]           dia,
  output logic [SCN-1:0]           do0,
  output logic [SCN-1:0]           do1,
  output logic [SCN-1:0]           do2,
  output logic [SCN-1:0]           do3,
  output logic [2:0]               dot,
  output logic [VCN-1:0]           dovc,
  output logic                     dov,
  input  logic                     doa
);

  localparam int PW = (VCN > 1) ? $clog2(VCN) : 1;

  // Output flit register and arbiter state
  logic [SCN-1:0] r_do0;
  logic [SCN-1:0] r_do1;
  logic [SCN-1:0] r_do2;
  logic [SCN-1:0] r_do3;
  logic [2:0]     r_dot;
  logic [VCN-1:0] r_dovc;
  logic           r_dov;
  logic [PW-1:0]  r_ptr;

  // Combinational arbitration signals
  logic [VCN-1:0] w_mask;
  logic [VCN-1:0] w_req;
  logic [VCN-1:0] w_grant;
  logic [PW-1:0]  w_gidx;
  logic           w_found;
  logic           w_load;
  logic [VCN-1:0] w_dia;
  logic           w_xfer;
  logic [PW-1:0]  w_ptr_nxt;
  logic [SCN-1:0] w_d0;
  logic [SCN-1:0] w_d1;
  logic [SCN-1:0] w_d2;
  logic [SCN-1:0] w_d3;
  logic [2:0]     w_dt;
  logic           w_head_only;
  logic           w_tail;

`ifdef VCMUX_PKTLOCK_EN
  logic           r_lock_vld;
  logic [PW-1:0]  r_lock_vc;

  // While a packet is locked, only the owning VC may request
  always_comb begin
    w_mask = '0;
    if (r_lock_vld) begin
      w_mask = ~(VCN'(1) << r_lock_vc);
    end else begin
      w_mask = '0;
    end
  end

  // Lock is taken by a head-only flit and released by the tail of that VC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_vld <= 1'b0;
      r_lock_vc  <= '0;
    end else if (w_xfer && w_head_only) begin
      r_lock_vld <= 1'b1;
      r_lock_vc  <= w_gidx;
    end else if (w_xfer && r_lock_vld && w_tail) begin
      r_lock_vld <= 1'b0;
      r_lock_vc  <= r_lock_vc;
    end else begin
      r_lock_vld <= r_lock_vld;
      r_lock_vc  <= r_lock_vc;
    end
  end
`else
  // Flit-level interleave: no VC is ever masked
  always_comb begin
    w_mask = '0;
  end
`endif

  // Request vector and stage-load condition; dia is held low during reset
  always_comb begin
    w_req  = div & ~w_mask;
    w_load = rst_n & (~r_dov | doa);
  end

  // Round-robin search: first request at or above ptr, wrapping modulo VCN
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < VCN; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= VCN) begin
        idx = idx - VCN;
      end else begin
        idx = idx;
      end
      if (!w_found && w_req[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = PW'(idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Accept handshake, next pointer and selected flit fields
  always_comb begin
    w_dia  = w_grant & {VCN{w_load}};
    w_xfer = |w_dia;
    if (int'(w_gidx) == VCN - 1) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gidx + PW'(1);
    end
    w_d0        = di0[w_gidx];
    w_d1        = di1[w_gidx];
    w_d2        = di2[w_gidx];
    w_d3        = di3[w_gidx];
    w_dt        = dit[w_gidx];
    w_head_only = w_dt[0] & ~w_dt[2];
    w_tail      = w_dt[2];
  end

  // Output flit stage: load on transfer, drain on accept, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_do0  <= '0;
      r_do1  <= '0;
      r_do2  <= '0;
      r_do3  <= '0;
      r_dot  <= 3'b000;
      r_dovc <= '0;
      r_dov  <= 1'b0;
    end else if (w_xfer) begin
      r_do0  <= w_d0;
      r_do1  <= w_d1;
      r_do2  <= w_d2;
      r_do3  <= w_d3;
      r_dot  <= w_dt;
      r_dovc <= w_grant;
      r_dov  <= 1'b1;
    end else if (r_dov && doa) begin
      r_dov  <= 1'b0;
    end else begin
      r_dov  <= r_dov;
    end
  end

  // Priority pointer moves just past the VC that was served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign dia  = w_dia;
  assign do0  = r_do0;
  assign do1  = r_do1;
  assign do2  = r_do2;
  assign do3  = r_do3;
  assign dot  = r_dot;
  assign dovc = r_dovc;
  assign dov  = r_dov;

endmodule

// File: tb/tb_vcmux_arb.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vcmux_arb: fixed vector table, random traffic
// against a rule-level reference model, and hand-written reset/lock sequences.
// ---------------------------------------------------------------------------
module tb_vcmux_arb;

  localparam int VCN = 2;
  localparam int DW  = 32;
  localparam int SCN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [VCN-1:0][SCN-1:0] di0, di1, di2, di3;
  logic [VCN-1:0][2:0]     dit;
  logic [VCN-1:0]          div;
  logic [VCN-1:0]          dia;
  logic [SCN-1:0]          do0, do1, do2, do3;
  logic [2:0]              dot;
  logic [VCN-1:0]          dovc;
  logic                    dov;
  logic                    doa;

  vcmux_arb #(.VCN(VCN), .DW(DW), .SCN(SCN)) dut (
    .clk(clk), .rst_n(rst_n),
    .di0(di0), .di1(di1), .di2(di2), .di3(di3),
    .dit(dit), .div(div), .dia(dia),
    .do0(do0), .do1(do1), .do2(do2), .do3(do3),
    .dot(dot), .dovc(dovc), .dov(dov), .doa(doa)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit             m_dov;
  logic [SCN-1:0] m_d[4];
  logic [2:0]     m_dot;
  logic [VCN-1:0] m_dovc;
  int             m_ptr;
  bit             m_lock;
  int             m_lock_vc;
  logic [VCN-1:0] m_dia;

  // Sampled DUT values
  logic [VCN-1:0] s_dia;
  logic           s_dov;
  logic [VCN-1:0] s_dovc;
  logic [SCN-1:0] s_d[4];
  logic [2:0]     s_dot;

  typedef struct {
    logic [1:0]  div;
    logic        doa;
    logic [1:0]  dia;
    logic        dov;
    logic [1:0]  dovc;
    logic [15:0] do0;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dov = 1'b0;
    for (int i = 0; i < 4; i++) m_d[i] = '0;
    m_dot     = 3'b000;
    m_dovc    = '0;
    m_ptr     = 0;
    m_lock    = 1'b0;
    m_lock_vc = 0;
  endtask

  // Which VC the rules say is accepted this cycle (one-hot, or zero)
  function automatic logic [VCN-1:0] model_dia();
    logic [VCN-1:0] r;
    r = '0;
    if (rst_n !== 1'b1) return r;
    if (m_dov && !doa) return r;
    for (int k = 0; k < VCN; k++) begin
      int idx;
      idx = (m_ptr + k) % VCN;
      if (div[idx] && (!m_lock || idx == m_lock_vc)) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_update(input logic [VCN-1:0] g1h);
    int g;
    g = -1;
    for (int i = 0; i < VCN; i++) if (g1h[i]) g = i;
    if (g >= 0) begin
      m_d[0] = di0[g];
      m_d[1] = di1[g];
      m_d[2] = di2[g];
      m_d[3] = di3[g];
      m_dot  = dit[g];
      m_dovc = g1h;
      m_dov  = 1'b1;
      m_ptr  = (g + 1) % VCN;
`ifdef VCMUX_PKTLOCK_EN
      if (dit[g][0] && !dit[g][2]) begin
        m_lock    = 1'b1;
        m_lock_vc = g;
      end else if (m_lock && dit[g][2]) begin
        m_lock = 1'b0;
      end
`endif
    end else if (m_dov && doa) begin
      m_dov = 1'b0;
    end
  endtask

  // One clock: sample dia at the falling edge, advance model at the rising
  // edge, sample registered outputs just after it
  task automatic tick();
    @(negedge clk);
    s_dia = dia;
    m_dia = model_dia();
    @(posedge clk);
    model_update(m_dia);
    #1;
    s_dov  = dov;
    s_dovc = dovc;
    s_d[0] = do0;
    s_d[1] = do1;
    s_d[2] = do2;
    s_d[3] = do3;
    s_dot  = dot;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_dia"}, 32'(s_dia), 32'(m_dia));
    chk({tag, "_dov"}, 32'(s_dov), 32'(m_dov));
    if (m_dov) begin
      chk({tag, "_dovc"}, 32'(s_dovc), 32'(m_dovc));
      chk({tag, "_dot"},  32'(s_dot),  32'(m_dot));
      for (int i = 0; i < 4; i++) chk({tag, "_do"}, 32'(s_d[i]), 32'(m_d[i]));
    end
  endtask

  task automatic set_fixed_data();
    di0[0] = 16'hAAAA; di0[1] = 16'h5555;
    di1[0] = 16'h1111; di1[1] = 16'h2222;
    di2[0] = 16'h3333; di2[1] = 16'h4444;
    di3[0] = 16'h6666; di3[1] = 16'h7777;
    dit[0] = 3'b010;   dit[1] = 3'b010;
  endtask

  initial begin
    // round robin, backpressure, single source, drain, stall corners
    tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 16'hAAAA};
    tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 16'h5555};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 16'hAAAA};
    tbl[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 16'h5555};
    tbl[4]  = '{2'b11, 1'b0, 2'b00, 1'b1, 2'b10, 16'h5555};
    tbl[5]  = '{2'b11, 1'b0, 2'b00, 1'b1, 2'b10, 16'h5555};
    tbl[6]  = '{2'b11, 1'b0, 2'b00, 1'b1, 2'b10, 16'h5555};
    tbl[7]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 16'hAAAA};
    tbl[8]  = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 16'h5555};
    tbl[9]  = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 16'h5555};
    tbl[10] = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 16'h5555};
    tbl[11] = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 16'h5555};
    tbl[12] = '{2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 16'h0000};
    tbl[13] = '{2'b01, 1'b0, 2'b01, 1'b1, 2'b01, 16'hAAAA};
    tbl[14] = '{2'b11, 1'b0, 2'b00, 1'b1, 2'b01, 16'hAAAA};
    tbl[15] = '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 16'hAAAA};
    tbl[16] = '{2'b00, 1'b0, 2'b00, 1'b1, 2'b01, 16'hAAAA};
    tbl[17] = '{2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 16'h0000};

    // Reset with both VCs requesting
    rst_n = 1'b0;
    div   = 2'b11;
    doa   = 1'b0;
    set_fixed_data();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dia",  32'(dia),  32'd0);
    chk("rst_dov",  32'(dov),  32'd0);
    chk("rst_dovc", 32'(dovc), 32'd0);
    chk("rst_do0",  32'(do0),  32'd0);
    chk("rst_dot",  32'(dot),  32'd0);
    doa   = 1'b1;
    rst_n = 1'b1;

    // Fixed vector table
    for (int i = 0; i < 18; i++) begin
      div = tbl[i].div;
      doa = tbl[i].doa;
      tick();
      chk($sformatf("tbl%0d_dia", i), 32'(s_dia), 32'(tbl[i].dia));
      chk($sformatf("tbl%0d_dov", i), 32'(s_dov), 32'(tbl[i].dov));
      if (tbl[i].dov) begin
        chk($sformatf("tbl%0d_dovc", i), 32'(s_dovc), 32'(tbl[i].dovc));
        chk($sformatf("tbl%0d_do0", i),  32'(s_d[0]), 32'(tbl[i].do0));
      end
    end

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      div = VCN'($urandom);
      doa = ($urandom_range(3) != 0);
      di0 = $urandom; di1 = $urandom; di2 = $urandom; di3 = $urandom;
      for (int v = 0; v < VCN; v++) begin
        case ($urandom_range(7))
          0, 1, 2: dit[v] = 3'b010;
          3, 4:    dit[v] = 3'b001;
          5, 6:    dit[v] = 3'b100;
          default: dit[v] = 3'($urandom);
        endcase
      end
      tick();
      chk_model("rnd");
    end

    // Mid-operation asynchronous reset while stalled
    set_fixed_data();
`ifdef VCMUX_PKTLOCK_EN
    // clear any random lock before the directed sequence
    #1 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
`endif
    div = 2'b01; doa = 1'b1;
    tick();
    div = 2'b00; doa = 1'b0;
    tick();
    chk("stall_dov", 32'(s_dov), 32'd1);
    #1;
    rst_n = 1'b0;
    div   = 2'b11;
    #1;
    chk("arst_dov",  32'(dov),  32'd0);
    chk("arst_dovc", 32'(dovc), 32'd0);
    chk("arst_dia",  32'(dia),  32'd0);
    model_reset();
    doa   = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("arst_rel_dia",  32'(s_dia),  32'h1);
    chk("arst_rel_dovc", 32'(s_dovc), 32'h1);

`ifdef VCMUX_PKTLOCK_EN
    // Packet lock: VC0 head/body/tail with VC1 requesting throughout
    begin
      logic [2:0] ty[4];
      logic [1:0] exp_vc[4];
      ty[0] = 3'b001; ty[1] = 3'b010; ty[2] = 3'b100; ty[3] = 3'b100;
      exp_vc[0] = 2'b01; exp_vc[1] = 2'b01; exp_vc[2] = 2'b01; exp_vc[3] = 2'b10;
      #1 rst_n = 1'b0;
      model_reset();
      #1 rst_n = 1'b1;
      div = 2'b11; doa = 1'b1;
      for (int i = 0; i < 4; i++) begin
        dit[0] = ty[i];
        tick();
        chk($sformatf("lock%0d_dia", i),  32'(s_dia),  32'(exp_vc[i]));
        chk($sformatf("lock%0d_dovc", i), 32'(s_dovc), 32'(exp_vc[i]));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcmux_arb.md
# vcmux_arb

Clocked virtual-channel multiplexer: the transmit-side counterpart of the VC buffer demux. It merges `VCN` per-VC flit channels onto one shared link, selects the winning VC by round-robin arbitration, and tags each output flit with a one-hot VC identifier. The identifier is the `divc` select for the downstream demux. The block sits at each router output port, between the per-VC output buffers and the inter-router link, and holds one registered flit stage.

## Interface
- `VCN`, 2, number of input VCs (≥2)
- `DW`, 32, link data width
- `SCN`, `DW/2`, width of each of the four data sub-channels
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `di0`,`di1`,`di2`,`di3`  in  `[VCN-1:0][SCN-1:0]`  per-VC data sub-channels
- `dit`  in  `[VCN-1:0][2:0]`  per-VC flit type, one-hot: `3'b001` head, `3'b010` body, `3'b100` tail
- `div`  in  `VCN`  per-VC flit valid
- `dia`  out  `VCN`  per-VC accept; flit on VC i is consumed when `div[i] & dia[i]` at a clock edge
- `do0`,`do1`,`do2`,`do3`  out  `SCN`  registered output data
- `dot`  out  3  registered output flit type
- `dovc`  out  `VCN`  registered one-hot VC tag of the output flit
- `dov`  out  1  output flit valid
- `doa`  in  1  downstream accept; output flit transfers when `dov & doa` at a clock edge

## Operation
- Output stage: one flit register holding `do*`, `dot`, `dovc` and the `dov` flag.
- The stage can load (`load`) when `!dov | doa`.
- Request vector: `req = div & ~mask`.
  - `mask` is 0 unless packet lock is active (see Configuration).
- Round-robin arbiter with priority pointer `ptr` (`$clog2(VCN)` bits):
  - The grant goes to the first `req` bit at or above `ptr`, wrapping modulo `VCN`.
  - `grant` is one-hot or zero and is combinational.
- `dia = grant & {VCN{load}}`. At most one `dia` bit is high per cycle.
- On a transfer of VC g:
  - The register loads `di*[g]`, `dit[g]` and `dovc = 1<<g`, and sets `dov=1`.
  - `ptr` becomes `(g+1) mod VCN`.
- If `dov & doa` and no grant occurs: `dov` goes to 0, and the data registers keep their values (don't-care).
- If `load` is 0: `grant` is still computed, but `dia` is 0 and `ptr` is unchanged.
- `dit` is forwarded unmodified. Invalid type codes are passed through and not checked.

## Timing
- Reset, asynchronous on `rst_n` low:
  - outputs: `dov=0`, `do0..do3=0`, `dot=0`, `dovc=0`
  - internal state: `ptr=0`, lock cleared
  - A flit held in the register is discarded.
  - `dia` is 0 while `rst_n` is low.
- Latency is 1 cycle. A flit accepted at edge n appears on `do*` with `dov=1` after edge n.
- Throughput is 1 flit/cycle while `doa` stays high. Stall plus accept in the same cycle (`dov & doa` together with a new grant) replaces the register contents with no bubble.
- While `dov & !doa`, the outputs are held stable and all `dia` bits are 0.
- `dia` depends combinationally on `doa` and `div`. There is no combinational path from `di*` or `dit` to any output.
- Simultaneous valids: exactly one VC is served per cycle. Each VC with a continuously asserted `div` is served within `VCN` transfers.

## Configuration
- Macro `VCMUX_PKTLOCK_EN`.
- Defined (packet-level lock):
  - When a head flit that is not also a tail is granted from VC g, the lock is set to g.
  - While locked, `mask = ~(1<<g)`, so only VC g can win.
  - The lock clears on the edge at which a tail flit from VC g transfers.
  - `ptr` still advances to g+1 when the lock is released.
- Undefined (flit-level interleave): `mask = 0` and there is no lock register. Flits of different VCs interleave freely; this is the default VC-router behaviour.

## Test plan
- Reset: hold `rst_n=0` with `div=2'b11` → `dia=0`, `dov=0`, `dovc=0`. Release it with `doa=1` → first edge accepts VC0 (`dia=2'b01`), `dovc=2'b01`.
- Round-robin: `VCN=2`, `div=2'b11` constant, `doa=1`, lock undefined → `dovc` sequence 01,10,01,10. VC0 data `0xAAAA`, VC1 data `0x5555` appear alternately on `do0`.
- Backpressure: `dov=1`, `doa=0` for 3 cycles → `do*` and `dovc` unchanged, `dia=0`. Raise `doa` → next flit follows with no bubble cycle.
- Single source: only `div[1]=1`, 4 flits, `doa=1` → 4 consecutive cycles with `dov=1` and `dovc=2'b10`. Then `div=0` → `dov=0` one cycle later.
- Packet lock (`VCMUX_PKTLOCK_EN`):
  - Stimulus: VC0 sends head, body, tail while `div[1]=1` throughout.
  - Required: `dovc` = 01,01,01,10. VC1 is served only after the VC0 tail transfers.
- Mid-operation reset: assert `rst_n=0` asynchronously while `dov=1`, `doa=0` → `dov` drops immediately without waiting for a clock edge. After release, arbitration restarts at VC0.
